neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

- Consumer end of the address-generator stream: takes one weight/neuron operand pair per valid cycle, as fetched from weight and neuron memory.
- Multiply-accumulates TAPS pairs, then scales, optionally rectifies and saturates the sum.
- Issues a single-cycle write of the result to neuron memory at an auto-incrementing write address.
- Sits between the memory read ports and the neuron-memory write port of the neural-network datapath.

## Interface
- TAPS, 4: pairs accumulated per output neuron (2..16).
- SHIFT, 6: arithmetic right shift applied to the sum (fixed-point rescale).
- WR_BASE, 8'h10: first write address after reset.
- WR_LAST, 8'h1F: last write address; the next address after it is WR_BASE.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- in_valid  input  1  weight_in/neuro_in carry a pair this cycle.
- weight_in  input  8  signed two's-complement weight.
- neuro_in  input  8  signed two's-complement neuron value.
- clear  input  1  synchronous abort of the partial group.
- relu_en  input  1  apply ReLU to the result; sampled on the completing cycle.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  8  write address; valid while wr_en=1, otherwise the next address.
- wr_data  output  8  signed result; valid while wr_en=1.
- tap_idx  output  4  index of the next pair to be accepted (0..TAPS-1).
- sat_flag  output  1  sticky: some result was clipped; cleared only by reset.

## Operation
- Reset (reset=0, asynchronous) values:
  - tap_idx=0, accumulator=0, wr_en=0, wr_data=8'h00, wr_addr=WR_BASE, sat_flag=0.
  - Reset mid-group discards the partial sum.
- Accepting a pair (in_valid=1, clear=0):
  - product = weight_in*neuro_in, signed 16-bit.
  - If tap_idx=0, acc <= product; otherwise acc <= acc + product.
  - Accumulator is 20 bits signed, so no internal overflow for TAPS≤16.
- Completing a group (pair accepted with tap_idx=TAPS-1):
  - sum = acc + product.
  - r = sum >>> SHIFT (arithmetic, floor toward -inf).
  - If relu_en and r<0, r=0.
  - Saturate r to [-128,127]; set sat_flag if clipped.
  - Register r into wr_data, pulse wr_en, tap_idx <= 0.
- in_valid=0: accumulator, tap_idx and wr_addr hold. Gaps of any length inside a group are legal.
- Address advance: on the cycle after a wr_en pulse, wr_addr advances by 1. From WR_LAST it wraps to WR_BASE.
- clear=1: tap_idx <= 0 and the accumulator is discarded.
  - clear wins over in_valid; that cycle's pair is dropped.
  - wr_addr and sat_flag are unaffected.
  - If a group completed on the previous edge, its wr_en pulse still occurs.

## Timing
- Latency: the pair completing a group is sampled on edge k. wr_en, wr_data and the current wr_addr are valid from edge k to edge k+1.
- wr_en is high for exactly one cycle per completed group; it is never high on consecutive cycles when TAPS≥2.
- Back-to-back groups sustain one write per TAPS cycles with in_valid held at 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic MAC: reset, then 4 pairs (16,8) with relu_en=0.
  - Required: sum 512, wr_data=8'h08, wr_addr=8'h10.
  - wr_en high one cycle after the 4th pair's edge; the next wr_addr is 8'h11.
- Negative and ReLU: 4 pairs (-16,8).
  - relu_en=0 requires wr_data=8'hF8.
  - Repeating with relu_en=1 requires wr_data=8'h00 and sat_flag=0.
- Floor and saturation:
  - Pairs (-1,1),(0,0),(0,0),(0,0) require wr_data=8'hFF.
  - Then 4 pairs (64,64) (sum 16384 → 256) require wr_data=8'h7F and sat_flag=1, which stays 1 afterwards.
- Gaps and clear:
  - 2 pairs (16,8), then in_valid=0 for 3 cycles, then 2 more (16,8): requires wr_data=8'h08.
  - 2 pairs, then clear=1 with in_valid=1, then 4 pairs (16,8): requires one write with 8'h08 and tap_idx=0 after clear.
- Address wrap: 16 groups with default parameters.
  - Required: wr_addr runs 8'h10..8'h1F, and the 17th write goes to 8'h10.
- Reset mid-operation: assert reset=0 asynchronously after 2 pairs and between clock edges.
  - Required: outputs reach reset values immediately.
  - After release, 4 pairs (16,8) write 8'h08 to 8'h10.

Source files
------------

// File: rtl/neuron_accumulator_if.sv
// Operand stream and neuron-memory write port of the neuron accumulator.
// master: the side feeding operand pairs and receiving write strobes.
// slave:  the accumulator itself.
interface neuron_accumulator_if;
    logic       in_valid;
    logic [7:0] weight_in;
    logic [7:0] neuro_in;
    logic       clear;
    logic       relu_en;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] tap_idx;
    logic       sat_flag;

    modport master (
        output in_valid, weight_in, neuro_in, clear, relu_en,
        input  wr_en, wr_addr, wr_data, tap_idx, sat_flag
    );

    modport slave (
        input  in_valid, weight_in, neuro_in, clear, relu_en,
        output wr_en, wr_addr, wr_data, tap_idx, sat_flag
    );
endinterface

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: multiply-accumulates TAPS weight/neuron pairs, rescales
// by an arithmetic right shift, optionally rectifies, saturates to 8 bits and
// issues a one-cycle write to neuron memory at an auto-incrementing address.
module neuron_accumulator #(
    parameter int unsigned TAPS    = 4,
    parameter int unsigned SHIFT   = 6,
    parameter logic [7:0]  WR_BASE = 8'h10,
    parameter logic [7:0]  WR_LAST = 8'h1F
) (
    input logic                  clk,
    input logic                  reset,
    neuron_accumulator_if.slave  bus
);

    localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);

    logic signed [19:0] acc_q;
    logic [3:0]         tap_q;
    logic               wr_en_q;
    logic [7:0]         wr_addr_q;
    logic [7:0]         wr_data_q;
    logic               sat_q;

    logic signed [15:0] w_ext;
    logic signed [15:0] n_ext;
    logic signed [15:0] product;
    logic signed [19:0] product_ext;
    logic signed [19:0] acc_next;
    logic signed [19:0] shifted;
    logic signed [19:0] rect;
    logic [7:0]         result;
    logic               clipped;
    logic               last_tap;

    // Product, running sum and the rescaled/rectified/saturated group result.
    always_comb begin
        w_ext       = {{8{bus.weight_in[7]}}, bus.weight_in};
        n_ext       = {{8{bus.neuro_in[7]}}, bus.neuro_in};
        product     = w_ext * n_ext;
        product_ext = {{4{product[15]}}, product};
        acc_next    = (tap_q == '0) ? product_ext : acc_q + product_ext;
        shifted     = acc_next >>> SHIFT;
        last_tap    = (tap_q == LAST_TAP);

        rect = shifted;
        if (bus.relu_en && shifted[19])
            rect = '0;

        result  = rect[7:0];
        clipped = 1'b0;
        if (!rect[19] && (|rect[19:7])) begin
            result  = 8'h7F;
            clipped = 1'b1;
        end else if (rect[19] && !(&rect[19:7])) begin
            result  = 8'h80;
            clipped = 1'b1;
        end
    end

    // Accumulator, tap counter, write strobe/data/address and sticky saturation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            tap_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= WR_BASE;
            wr_data_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;

            // Address moves on once the strobe that used it has been seen.
            if (wr_en_q)
                wr_addr_q <= (wr_addr_q == WR_LAST) ? WR_BASE : wr_addr_q + 8'd1;

            if (bus.clear) begin
                acc_q <= '0;
                tap_q <= '0;
            end else if (bus.in_valid) begin
                if (last_tap) begin
                    acc_q     <= '0;
                    tap_q     <= '0;
                    wr_en_q   <= 1'b1;
                    wr_data_q <= result;
                    if (clipped)
                        sat_q <= 1'b1;
                end else begin
                    acc_q <= acc_next;
                    tap_q <= tap_q + 4'd1;
                end
            end
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.tap_idx  = tap_q;
    assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator with a write scoreboard.
module tb_neuron_accumulator;

    localparam int TAPS  = 4;
    localparam int SHIFT = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    neuron_accumulator_if bus ();

    neuron_accumulator #(
        .TAPS(4),
        .SHIFT(6),
        .WR_BASE(8'h10),
        .WR_LAST(8'h1F)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sbq[$];
    int         tests = 0;
    int         fails = 0;
    int         m_sum = 0;
    int         m_tap = 0;
    logic [7:0] m_addr = 8'h10;
    logic       m_sat = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] last_addr = 8'h00;
    int         writes = 0;
    logic       prev_wr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any write the DUT issued on that edge.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) begin
            writes++;
            check("wr_en_not_consecutive", {31'd0, prev_wr}, 32'd0);
            check("sb_pending", {31'd0, (sbq.size() > 0)}, 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("wr_addr", {24'd0, bus.wr_addr}, {24'd0, e.addr});
                check("wr_data", {24'd0, bus.wr_data}, {24'd0, e.data});
            end
            last_data = bus.wr_data;
            last_addr = bus.wr_addr;
        end
        prev_wr = bus.wr_en;
    endtask

    task automatic pair(input logic signed [7:0] w, input logic signed [7:0] n, input logic relu);
        int prod;
        int r;
        bus.in_valid  = 1'b1;
        bus.clear     = 1'b0;
        bus.weight_in = w;
        bus.neuro_in  = n;
        bus.relu_en   = relu;
        prod  = int'(w) * int'(n);
        m_sum = (m_tap == 0) ? prod : m_sum + prod;
        if (m_tap == TAPS - 1) begin
            r = m_sum >>> SHIFT;
            if (relu && r < 0) r = 0;
            if (r > 127) begin
                r = 127;
                m_sat = 1'b1;
            end else if (r < -128) begin
                r = -128;
                m_sat = 1'b1;
            end
            sbq.push_back({m_addr, r[7:0]});
            m_addr = (m_addr == 8'h1F) ? 8'h10 : m_addr + 8'd1;
            m_tap  = 0;
        end else begin
            m_tap++;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic group4(input logic signed [7:0] w, input logic signed [7:0] n, input logic relu);
        repeat (4) pair(w, n, relu);
    endtask

    initial begin
        int w0;
        logic [7:0] exp_addr;
        bus.in_valid  = 1'b0;
        bus.weight_in = 8'h00;
        bus.neuro_in  = 8'h00;
        bus.clear     = 1'b0;
        bus.relu_en   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en",    {31'd0, bus.wr_en},    32'd0);
        check("rst_wr_data",  {24'd0, bus.wr_data},  32'h00);
        check("rst_wr_addr",  {24'd0, bus.wr_addr},  32'h10);
        check("rst_tap_idx",  {28'd0, bus.tap_idx},  32'd0);
        check("rst_sat_flag", {31'd0, bus.sat_flag}, 32'd0);
        reset = 1'b1;
        idle(1);

        // Basic MAC: 4 x (16,8) -> 512 >>> 6 = 8
        w0 = writes;
        group4(8'sd16, 8'sd8, 1'b0);
        check("basic_write_latency", writes - w0, 1);
        check("basic_data", {24'd0, last_data}, 32'h08);
        check("basic_addr", {24'd0, last_addr}, 32'h10);
        idle(1);
        check("basic_wr_en_low", {31'd0, bus.wr_en}, 32'd0);
        check("basic_next_addr", {24'd0, bus.wr_addr}, 32'h11);

        // Negative and ReLU
        group4(-8'sd16, 8'sd8, 1'b0);
        check("neg_data", {24'd0, last_data}, 32'hF8);
        group4(-8'sd16, 8'sd8, 1'b1);
        check("relu_data", {24'd0, last_data}, 32'h00);
        check("relu_sat", {31'd0, bus.sat_flag}, 32'd0);

        // Floor toward -inf, then saturation
        pair(-8'sd1, 8'sd1, 1'b0);
        pair(8'sd0, 8'sd0, 1'b0);
        pair(8'sd0, 8'sd0, 1'b0);
        pair(8'sd0, 8'sd0, 1'b0);
        check("floor_data", {24'd0, last_data}, 32'hFF);
        group4(8'sd64, 8'sd64, 1'b0);
        check("sat_data", {24'd0, last_data}, 32'h7F);
        check("sat_flag_set", {31'd0, bus.sat_flag}, 32'd1);
        group4(8'sd16, 8'sd8, 1'b0);
        check("sat_flag_sticky", {31'd0, bus.sat_flag}, 32'd1);

        // Gaps inside a group
        pair(8'sd16, 8'sd8, 1'b0);
        pair(8'sd16, 8'sd8, 1'b0);
        idle(3);
        check("gap_tap_hold", {28'd0, bus.tap_idx}, 32'd2);
        pair(8'sd16, 8'sd8, 1'b0);
        pair(8'sd16, 8'sd8, 1'b0);
        check("gap_data", {24'd0, last_data}, 32'h08);

        // Clear discards the partial group and the pair offered with it
        w0 = writes;
        pair(8'sd16, 8'sd8, 1'b0);
        pair(8'sd16, 8'sd8, 1'b0);
        bus.in_valid  = 1'b1;
        bus.clear     = 1'b1;
        bus.weight_in = 8'sd16;
        bus.neuro_in  = 8'sd8;
        m_tap = 0;
        tick();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_tap_idx", {28'd0, bus.tap_idx}, 32'd0);
        group4(8'sd16, 8'sd8, 1'b0);
        check("clear_one_write", writes - w0, 1);
        check("clear_data", {24'd0, last_data}, 32'h08);
        idle(2);

        // Asynchronous reset between edges, mid-group
        pair(8'sd16, 8'sd8, 1'b0);
        pair(8'sd16, 8'sd8, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("arst_tap_idx",  {28'd0, bus.tap_idx},  32'd0);
        check("arst_wr_addr",  {24'd0, bus.wr_addr},  32'h10);
        check("arst_wr_en",    {31'd0, bus.wr_en},    32'd0);
        check("arst_wr_data",  {24'd0, bus.wr_data},  32'h00);
        check("arst_sat_flag", {31'd0, bus.sat_flag}, 32'd0);
        m_tap  = 0;
        m_addr = 8'h10;
        m_sat  = 1'b0;
        sbq.delete();
        @(negedge clk);
        reset = 1'b1;
        group4(8'sd16, 8'sd8, 1'b0);
        check("arst_after_data", {24'd0, last_data}, 32'h08);
        check("arst_after_addr", {24'd0, last_addr}, 32'h10);

        // Address wrap: 16 more groups, addresses 11..1F then back to 10
        for (int g = 1; g <= 16; g++) begin
            for (int t = 0; t < TAPS; t++)
                pair(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
            exp_addr = (g == 16) ? 8'h10 : 8'(8'h10 + g);
            check("wrap_addr", {24'd0, last_addr}, {24'd0, exp_addr});
            check("wrap_sat", {31'd0, bus.sat_flag}, {31'd0, m_sat});
        end

        idle(2);
        check("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
